// File: rtl/l7_window_addr_gen.sv
// Layer-7 window address generator: raster-scans the output feature map with
// a configurable stride, issuing one read address per position and stalling until win_done.
module l7_window_addr_gen #(
  parameter int unsigned IMG_W     = 16,
  parameter int unsigned IMG_H     = 16,
  parameter int unsigned STRIDE    = 1,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr,
  input  logic              win_done,
  output logic              x_zero,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        x_pos,
  output logic [7:0]        y_pos,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0]        LAST_X    = 8'(((IMG_W - 1) / STRIDE) * STRIDE);
  localparam logic [7:0]        LAST_Y    = 8'(((IMG_H - 1) / STRIDE) * STRIDE);
  localparam logic [7:0]        POS_STEP  = 8'(STRIDE);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(STRIDE * IMG_W);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  logic [1:0]        state_q, state_d;
  logic [7:0]        x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic              av_q, av_d, xz_q, xz_d, busy_q, busy_d, done_q, done_d;

  // Every output flop is loaded from next-state values so pulses align with the state they belong to.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    av_d       = 1'b0;
    xz_d       = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    if (clr) begin
      state_d    = S_IDLE;
      x_d        = '0;
      y_d        = '0;
      row_base_d = '0;
      addr_d     = '0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_d = 1'b0;
          if (start) begin
            state_d    = S_ISSUE;
            x_d        = '0;
            y_d        = '0;
            row_base_d = BASE;
            addr_d     = BASE;
            av_d       = 1'b1;
            xz_d       = 1'b1;
            busy_d     = 1'b1;
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT;
          busy_d  = 1'b1;
        end
        S_WAIT: begin
          busy_d = 1'b1;
          if (win_done) begin
            if (x_q == LAST_X && y_q == LAST_Y) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else if (x_q == LAST_X) begin
              state_d    = S_ISSUE;
              x_d        = '0;
              y_d        = y_q + POS_STEP;
              row_base_d = row_base_q + ROW_STEP;
              addr_d     = row_base_q + ROW_STEP;
              av_d       = 1'b1;
              xz_d       = 1'b1;
            end else begin
              state_d = S_ISSUE;
              x_d     = x_q + POS_STEP;
              addr_d  = addr_q + ADDR_STEP;
              av_d    = 1'b1;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      av_q       <= 1'b0;
      xz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      av_q       <= av_d;
      xz_q       <= xz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign x_zero     = xz_q;
  assign addr_valid = av_q;
  assign rd_addr    = addr_q;
  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/l7_window_addr_gen.md
Name: l7_window_addr_gen

Overview:
- Initiator side of the layer-7 window-timing handshake.
- Walks the output feature map in raster order with a configurable stride.
- For each position it issues one read address and drives x_zero at the start of every row.
- It then stalls until the window-timing counter returns its window-complete strobe on win_done, and only then advances to the next position.

Parameters:
IMG_W, 16, feature-map width in pixels (>=1)
IMG_H, 16, feature-map height in rows (>=1)
STRIDE, 1, step in x and y (>=1)
ADDR_W, 8, read-address width
BASE_ADDR, 0, address of pixel (0,0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a frame scan
clr  input  1  synchronous abort, returns to IDLE
win_done  input  1  window-complete strobe from the timing counter
x_zero  output  1  high in the ISSUE cycle of a position with x==0
addr_valid  output  1  high for exactly one cycle per position (ISSUE)
rd_addr  output  ADDR_W  BASE_ADDR + y*IMG_W + x, mod 2^ADDR_W
x_pos  output  8  current column
y_pos  output  8  current row
busy  output  1  high in ISSUE and WAIT
done  output  1  one-cycle pulse when the frame completes

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; x_pos, y_pos, rd_addr, row_base all 0; x_zero, addr_valid, busy, done all 0.
- Definitions:
  - LAST_X = largest multiple of STRIDE that is <= IMG_W-1.
  - LAST_Y = same rule applied to IMG_H-1.
- Addressing:
  - Kept incrementally in a row_base register, no multiplier.
  - rd_addr = row_base + x_pos.
  - Advancing x adds STRIDE to the address.
  - Row change sets row_base += STRIDE*IMG_W and x_pos=0.
  - All address sums wrap modulo 2^ADDR_W.
- States:
  - IDLE:
    - Outputs low.
    - start=1 -> ISSUE, with x_pos=0, y_pos=0, row_base=BASE_ADDR.
  - ISSUE (exactly 1 cycle):
    - addr_valid=1.
    - x_zero = (x_pos==0).
    - Next state WAIT unconditionally.
  - WAIT:
    - Hold x_pos, y_pos, rd_addr. addr_valid=0, x_zero=0.
    - On win_done=1:
      - If x_pos==LAST_X and y_pos==LAST_Y -> DONE.
      - Else if x_pos==LAST_X -> y_pos+=STRIDE, x_pos=0, then ISSUE.
      - Else -> x_pos+=STRIDE, then ISSUE.
  - DONE:
    - done=1 for one cycle, busy=0.
    - -> IDLE.
    - x_pos and y_pos keep their last values until the next start.
- Latency:
  - start to first addr_valid: 1 cycle (registered).
  - win_done to next addr_valid: 1 cycle.
  - Each position therefore costs at least 2 cycles.
- Ignored inputs:
  - win_done is ignored in IDLE, ISSUE and DONE. A win_done arriving in the ISSUE cycle is dropped, not queued.
  - start is ignored in ISSUE, WAIT and DONE.
- clr:
  - clr=1 in any state -> IDLE next cycle.
  - All position registers return to 0; no done pulse is generated.
  - clr has priority over start and win_done in the same cycle.
- Asynchronous reset mid-scan: immediately forces the reset values above. No residual pulse on done or addr_valid after rst deasserts.
- Degenerate frame IMG_W=IMG_H=1: a single ISSUE with x_zero=1; the first win_done leads to DONE.
- Outputs are registered; x_zero and addr_valid never glitch between states.

Test Plan:
- Raster scan, IMG_W=4, IMG_H=3, STRIDE=1, BASE_ADDR=0; start, then answer every addr_valid with win_done 3 cycles later -> rd_addr sequence 0..11; x_zero high only at addresses 0, 4 and 8; done pulses once, 1 cycle after the 12th win_done; busy low afterwards.
- Strided scan, IMG_W=5, IMG_H=5, STRIDE=2 -> positions (0,0),(2,0),(4,0),(0,2)...(4,4); addresses 0,2,4,10,12,14,20,22,24; 9 addr_valid pulses; x_zero on 0, 10 and 20.
- Address wrap, ADDR_W=4, BASE_ADDR=14, IMG_W=4, IMG_H=2 -> addresses 14,15,0,1,2,3,4,5.
- Protocol abuse:
  - Assert win_done in the same cycle as addr_valid -> ignored; the block stays in WAIT until a later win_done.
  - Pulse start while busy -> no restart; the sequence continues unchanged.
- Abort and reset:
  - clr during WAIT at position (2,1) -> IDLE next cycle with all outputs 0 and no done pulse; a following start restarts at address BASE_ADDR.
  - rst low mid-scan -> outputs clear asynchronously, before the next clk edge.
- 1x1 frame -> exactly one addr_valid with x_zero=1; done follows 1 cycle after win_done.
